// File: rtl/pc_predict_if.sv
// pc_predict_if: fetch-side bundle of the pc_predict block.
//   master modport (pc_predict side):
//     out pc, ce                  instruction memory address / chip enable
//     out pred_taken_o            current pc predicted taken
//     out pred_target_o           predicted target (0 when no BTB hit)
//     in  stall_i                 hold pc
//     in  flush_i, new_pc_i       exception redirect
//     in  fix_valid_i, fix_pc_i   mispredict redirect
//     in  upd_valid_i, upd_pc_i,
//         upd_taken_i, upd_target_i  BTB training from branch resolution
//   slave modport: the same signals seen from the pipeline side.
interface pc_predict_if #(
  parameter int AW = 32
);
  logic [AW-1:0] pc;
  logic          ce;
  logic          pred_taken_o;
  logic [AW-1:0] pred_target_o;
  logic          stall_i;
  logic          flush_i;
  logic [AW-1:0] new_pc_i;
  logic          fix_valid_i;
  logic [AW-1:0] fix_pc_i;
  logic          upd_valid_i;
  logic [AW-1:0] upd_pc_i;
  logic          upd_taken_i;
  logic [AW-1:0] upd_target_i;

  modport master (
    output pc, ce, pred_taken_o, pred_target_o,
    input  stall_i, flush_i, new_pc_i, fix_valid_i, fix_pc_i,
    input  upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i
  );

  modport slave (
    input  pc, ce, pred_taken_o, pred_target_o,
    output stall_i, flush_i, new_pc_i, fix_valid_i, fix_pc_i,
    output upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i
  );
endinterface

// File: rtl/pc_predict.sv
// pc_predict: fetch-address generator with reset vector, stall, exception and
// mispredict redirects, and a direct-mapped BTB with 2-bit saturating counters.
//   clk  in  rising-edge clock
//   rst  in  synchronous active-high reset (ce=0, pc=RESET_ADDR, BTB invalidated)
//   bus  pc_predict_if.master (see the interface file for the signal list)
// Next-pc priority while ce=1: flush > fix > stall > prediction > pc+INST_BYTES.
module pc_predict #(
  parameter int            AW          = 32,
  parameter logic [AW-1:0] RESET_ADDR  = {AW{1'b0}},
  parameter int            INST_BYTES  = 4,
  parameter int            BTB_ENTRIES = 16,
  parameter bit            PRED_EN     = 1'b1
) (
  input logic          clk,
  input logic          rst,
  pc_predict_if.master bus
);
  localparam int OB = $clog2(INST_BYTES);
  localparam int IB = $clog2(BTB_ENTRIES);
  localparam int TW = AW - OB - IB;

  // 2-bit saturating counter helpers
  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

  logic [AW-1:0] r_pc;
  logic          r_ce;
  logic          r_valid  [BTB_ENTRIES];
  logic [TW-1:0] r_tag    [BTB_ENTRIES];
  logic [AW-1:0] r_target [BTB_ENTRIES];
  logic [1:0]    r_ctr    [BTB_ENTRIES];

  logic [IB-1:0] w_lk_idx;
  logic [TW-1:0] w_lk_tag;
  logic          w_lk_hit;
  logic          w_pred_taken;
  logic [AW-1:0] w_pred_target;
  logic [IB-1:0] w_up_idx;
  logic [TW-1:0] w_up_tag;
  logic          w_up_hit;

  // BTB lookup on the current fetch address; reads pre-update contents
  always_comb begin
    // shifting the whole address keeps the byte-offset bits out of idx/tag
    w_lk_idx = IB'(r_pc >> OB);
    w_lk_tag = TW'(r_pc >> (OB + IB));
    w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    if (w_lk_hit) begin
      w_pred_target = r_target[w_lk_idx];
      w_pred_taken  = PRED_EN && r_ce && r_ctr[w_lk_idx][1];
    end else begin
      w_pred_target = {AW{1'b0}};
      w_pred_taken  = 1'b0;
    end
  end

  // BTB probe for the resolved branch being trained
  always_comb begin
    w_up_idx = IB'(bus.upd_pc_i >> OB);
    w_up_tag = TW'(bus.upd_pc_i >> (OB + IB));
    w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
  end

  // Fetch address and chip enable; ce=0 parks pc on the reset vector
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ce <= 1'b0;
      r_pc <= RESET_ADDR;
    end else if (!r_ce) begin
      r_ce <= 1'b1;
      r_pc <= RESET_ADDR;
    end else if (bus.flush_i) begin
      r_pc <= bus.new_pc_i;
    end else if (bus.fix_valid_i) begin
      r_pc <= bus.fix_pc_i;
    end else if (bus.stall_i) begin
      r_pc <= r_pc;
    end else if (w_pred_taken) begin
      r_pc <= w_pred_target;
    end else begin
      r_pc <= r_pc + AW'(INST_BYTES);
    end
  end

  // BTB training; only valid bits are reset, payload is written on allocate
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
      end
    end else if (bus.upd_valid_i) begin
      if (w_up_hit) begin
        if (bus.upd_taken_i) begin
          r_ctr[w_up_idx]    <= sat_inc(r_ctr[w_up_idx]);
          r_target[w_up_idx] <= bus.upd_target_i;
        end else begin
          r_ctr[w_up_idx] <= sat_dec(r_ctr[w_up_idx]);
        end
      end else if (bus.upd_taken_i) begin
        // allocate or replace an aliasing entry as weakly taken
        r_valid[w_up_idx]  <= 1'b1;
        r_tag[w_up_idx]    <= w_up_tag;
        r_target[w_up_idx] <= bus.upd_target_i;
        r_ctr[w_up_idx]    <= 2'b10;
      end
    end
  end

  assign bus.pc            = r_pc;
  assign bus.ce            = r_ce;
  assign bus.pred_taken_o  = w_pred_taken;
  assign bus.pred_target_o = w_pred_target;
endmodule

// File: tb/tb_pc_predict.sv
// tb_pc_predict: directed and randomized checks of pc_predict against a
// behavioural model. Two instances share all inputs: dut (PRED_EN=1) and
// dut_np (PRED_EN=0).
module tb_pc_predict;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pc_predict_if #(.AW(32)) bus ();
  pc_predict_if #(.AW(32)) bus_np ();

  pc_predict #(.AW(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  pc_predict #(.AW(32), .PRED_EN(1'b0)) dut_np (.clk(clk), .rst(rst), .bus(bus_np));

  assign bus_np.stall_i      = bus.stall_i;
  assign bus_np.flush_i      = bus.flush_i;
  assign bus_np.new_pc_i     = bus.new_pc_i;
  assign bus_np.fix_valid_i  = bus.fix_valid_i;
  assign bus_np.fix_pc_i     = bus.fix_pc_i;
  assign bus_np.upd_valid_i  = bus.upd_valid_i;
  assign bus_np.upd_pc_i     = bus.upd_pc_i;
  assign bus_np.upd_taken_i  = bus.upd_taken_i;
  assign bus_np.upd_target_i = bus.upd_target_i;

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc, m2_pc;
  logic        m_ce, m2_ce;
  bit          m_v   [16];
  logic [31:0] m_tag [16];
  logic [31:0] m_tgt [16];
  int          m_ctr [16];

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 32'd4) % 32'd16);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a / 32'd64;
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_v[idx_of(a)] && (m_tag[idx_of(a)] == tag_of(a));
  endfunction

  function automatic bit exp_taken(input logic [31:0] a, input logic ce);
    return ce && m_hit(a) && (m_ctr[idx_of(a)] >= 2);
  endfunction

  function automatic logic [31:0] exp_target(input logic [31:0] a);
    return m_hit(a) ? m_tgt[idx_of(a)] : 32'h0;
  endfunction

  function automatic logic [31:0] next_pc(input logic ce, input logic [31:0] a,
                                          input bit pt, input logic [31:0] ptg);
    if (!ce) return 32'h0;
    if (bus.flush_i) return bus.new_pc_i;
    if (bus.fix_valid_i) return bus.fix_pc_i;
    if (bus.stall_i) return a;
    if (pt) return ptg;
    return a + 32'd4;
  endfunction

  // one clock: advance the model at the edge, return at the falling edge
  task automatic step();
    bit          pt;
    logic [31:0] ptg;
    int          ui;
    @(posedge clk);
    pt  = exp_taken(m_pc, m_ce);
    ptg = exp_target(m_pc);
    if (rst) begin
      m_ce = 1'b0; m_pc = 32'h0; m2_ce = 1'b0; m2_pc = 32'h0;
      for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
    end else begin
      m_pc  = next_pc(m_ce, m_pc, pt, ptg);
      m_ce  = 1'b1;
      m2_pc = next_pc(m2_ce, m2_pc, 1'b0, 32'h0);
      m2_ce = 1'b1;
      if (bus.upd_valid_i) begin
        ui = idx_of(bus.upd_pc_i);
        if (m_hit(bus.upd_pc_i)) begin
          if (bus.upd_taken_i) begin
            m_ctr[ui] = (m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3;
            m_tgt[ui] = bus.upd_target_i;
          end else begin
            m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
          end
        end else if (bus.upd_taken_i) begin
          m_v[ui] = 1'b1; m_tag[ui] = tag_of(bus.upd_pc_i);
          m_tgt[ui] = bus.upd_target_i; m_ctr[ui] = 2;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.stall_i = 1'b0; bus.flush_i = 1'b0; bus.new_pc_i = 32'h0;
    bus.fix_valid_i = 1'b0; bus.fix_pc_i = 32'h0;
    bus.upd_valid_i = 1'b0; bus.upd_pc_i = 32'h0;
    bus.upd_taken_i = 1'b0; bus.upd_target_i = 32'h0;
  endtask

  task automatic redirect(input logic [31:0] a);
    bus.fix_valid_i = 1'b1; bus.fix_pc_i = a;
    step();
    bus.fix_valid_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (bus.ce !== 1'b0 || bus.pc !== 32'h0) begin
        bad++; $display("FAIL reset_hold: ce=%b pc=%h want ce=0 pc=0", bus.ce, bus.pc);
      end
    end
    rst = 1'b0;
    step();
    total++;
    if (bus.ce !== 1'b1 || bus.pc !== 32'h0) begin
      bad++; $display("FAIL reset_first_fetch: ce=%b pc=%h want ce=1 pc=0", bus.ce, bus.pc);
    end
    for (int i = 1; i < 3; i++) begin
      step();
      total++;
      if (bus.pc !== 32'(i * 4)) begin
        bad++; $display("FAIL reset_seq: pc=%h want %h", bus.pc, 32'(i * 4));
      end
    end
  endtask

  task automatic test_stall();
    redirect(32'h20);
    bus.stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (bus.pc !== 32'h20) begin
        bad++; $display("FAIL stall_hold: pc=%h want 00000020", bus.pc);
      end
    end
    bus.stall_i = 1'b0;
    step();
    total++;
    if (bus.pc !== 32'h24) begin
      bad++; $display("FAIL stall_release: pc=%h want 00000024", bus.pc);
    end
  endtask

  task automatic test_priority();
    bus.flush_i = 1'b1; bus.new_pc_i = 32'h180;
    bus.fix_valid_i = 1'b1; bus.fix_pc_i = 32'h40; bus.stall_i = 1'b1;
    step();
    clear_inputs();
    total++;
    if (bus.pc !== 32'h180) begin
      bad++; $display("FAIL priority_flush: pc=%h want 00000180", bus.pc);
    end
    bus.fix_valid_i = 1'b1; bus.fix_pc_i = 32'h40; bus.stall_i = 1'b1;
    step();
    clear_inputs();
    total++;
    if (bus.pc !== 32'h40) begin
      bad++; $display("FAIL priority_fix_over_stall: pc=%h want 00000040", bus.pc);
    end
  endtask

  task automatic test_btb_train();
    bus.upd_valid_i = 1'b1; bus.upd_pc_i = 32'h10;
    bus.upd_taken_i = 1'b1; bus.upd_target_i = 32'h40;
    redirect(32'h0C);
    bus.upd_valid_i = 1'b0;
    total++;
    if (bus.pc !== 32'h0C || bus.pred_taken_o !== 1'b0) begin
      bad++; $display("FAIL train_0c: pc=%h pt=%b want 0000000c/0", bus.pc, bus.pred_taken_o);
    end
    step();
    total++;
    if (bus.pc !== 32'h10 || bus.pred_taken_o !== 1'b1 || bus.pred_target_o !== 32'h40) begin
      bad++; $display("FAIL train_hit: pc=%h pt=%b tgt=%h want 00000010/1/00000040",
                      bus.pc, bus.pred_taken_o, bus.pred_target_o);
    end
    step();
    total++;
    if (bus.pc !== 32'h40) begin
      bad++; $display("FAIL train_jump: pc=%h want 00000040", bus.pc);
    end
    bus.upd_valid_i = 1'b1; bus.upd_pc_i = 32'h10; bus.upd_taken_i = 1'b0;
    step();
    step();
    bus.upd_valid_i = 1'b0;
    redirect(32'h10);
    total++;
    if (bus.pred_taken_o !== 1'b0 || bus.pred_target_o !== 32'h40) begin
      bad++; $display("FAIL train_weakened: pt=%b tgt=%h want 0/00000040",
                      bus.pred_taken_o, bus.pred_target_o);
    end
    step();
    total++;
    if (bus.pc !== 32'h14) begin
      bad++; $display("FAIL train_fallthrough: pc=%h want 00000014", bus.pc);
    end
  endtask

  task automatic test_alias();
    redirect(32'h50);
    total++;
    if (bus.pred_taken_o !== 1'b0 || bus.pred_target_o !== 32'h0) begin
      bad++; $display("FAIL alias_miss: pt=%b tgt=%h want 0/0", bus.pred_taken_o, bus.pred_target_o);
    end
    bus.upd_valid_i = 1'b1; bus.upd_pc_i = 32'h50;
    bus.upd_taken_i = 1'b1; bus.upd_target_i = 32'h100;
    step();
    bus.upd_valid_i = 1'b0;
    redirect(32'h10);
    total++;
    if (bus.pred_taken_o !== 1'b0 || bus.pred_target_o !== 32'h0) begin
      bad++; $display("FAIL alias_evicted: pt=%b tgt=%h want 0/0", bus.pred_taken_o, bus.pred_target_o);
    end
    redirect(32'h50);
    total++;
    if (bus.pred_taken_o !== 1'b1 || bus.pred_target_o !== 32'h100) begin
      bad++; $display("FAIL alias_replaced: pt=%b tgt=%h want 1/00000100",
                      bus.pred_taken_o, bus.pred_target_o);
    end
    step();
    total++;
    if (bus.pc !== 32'h100) begin
      bad++; $display("FAIL alias_jump: pc=%h want 00000100", bus.pc);
    end
  endtask

  task automatic test_wrap();
    redirect(32'h50);
    total++;
    if (bus_np.pc !== 32'h50 || bus_np.pred_taken_o !== 1'b0 || bus_np.pred_target_o !== 32'h100) begin
      bad++; $display("FAIL nopred_lookup: pc=%h pt=%b tgt=%h want 00000050/0/00000100",
                      bus_np.pc, bus_np.pred_taken_o, bus_np.pred_target_o);
    end
    step();
    total++;
    if (bus_np.pc !== 32'h54 || bus.pc !== 32'h100) begin
      bad++; $display("FAIL nopred_seq: np_pc=%h pc=%h want 00000054/00000100", bus_np.pc, bus.pc);
    end
    redirect(32'hFFFF_FFFC);
    total++;
    if (bus.pc !== 32'hFFFF_FFFC) begin
      bad++; $display("FAIL wrap_top: pc=%h want fffffffc", bus.pc);
    end
    step();
    total++;
    if (bus.pc !== 32'h0 || bus_np.pc !== 32'h0) begin
      bad++; $display("FAIL wrap_zero: pc=%h np_pc=%h want 0", bus.pc, bus_np.pc);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rst             = ($urandom_range(0, 79) == 0);
      bus.flush_i     = ($urandom_range(0, 15) == 0);
      bus.new_pc_i    = 32'($urandom_range(0, 63)) * 32'd4;
      bus.fix_valid_i = ($urandom_range(0, 9) == 0);
      bus.fix_pc_i    = 32'($urandom_range(0, 63)) * 32'd4;
      bus.stall_i     = ($urandom_range(0, 4) == 0);
      bus.upd_valid_i = ($urandom_range(0, 2) == 0);
      bus.upd_pc_i    = 32'($urandom_range(0, 63)) * 32'd4;
      bus.upd_taken_i = ($urandom_range(0, 2) != 0);
      bus.upd_target_i = 32'($urandom_range(0, 63)) * 32'd4;
      step();
      total++;
      if (bus.ce !== m_ce || bus.pc !== m_pc) begin
        bad++; $display("FAIL rand_pc[%0d]: ce=%b pc=%h want %b/%h", n, bus.ce, bus.pc, m_ce, m_pc);
      end
      total++;
      if (bus.pred_taken_o !== exp_taken(m_pc, m_ce) || bus.pred_target_o !== exp_target(m_pc)) begin
        bad++; $display("FAIL rand_pred[%0d]: pt=%b tgt=%h want %b/%h", n, bus.pred_taken_o,
                        bus.pred_target_o, exp_taken(m_pc, m_ce), exp_target(m_pc));
      end
      total++;
      if (bus_np.ce !== m2_ce || bus_np.pc !== m2_pc || bus_np.pred_taken_o !== 1'b0 ||
          bus_np.pred_target_o !== exp_target(m2_pc)) begin
        bad++; $display("FAIL rand_np[%0d]: ce=%b pc=%h pt=%b tgt=%h want %b/%h/0/%h", n, bus_np.ce,
                        bus_np.pc, bus_np.pred_taken_o, bus_np.pred_target_o, m2_ce, m2_pc,
                        exp_target(m2_pc));
      end
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_stall();
    test_priority();
    test_btb_train();
    test_alias();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
